// File: rtl/qdrc_cal_pkg.sv
// Purpose: shared types and constants for the QDR hardware calibration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qdrc_cal_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SEL_BIT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CHECK,
    ST_CENTRE,
    ST_ALIGN,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

  localparam logic [1:0] FAIL_NONE      = 2'd0;
  localparam logic [1:0] FAIL_NARROW    = 2'd1;
  localparam logic [1:0] FAIL_RDY_TO    = 2'd2;
  localparam logic [1:0] FAIL_SAMPLE_TO = 2'd3;

  // {rise, fall} patterns that count as a clean eye sample
  localparam logic [1:0] GOOD_RISE = 2'b10;
  localparam logic [1:0] GOOD_FALL = 2'b01;

  function automatic logic is_good(input logic valid, input logic [1:0] value);
    return valid && ((value == GOOD_RISE) || (value == GOOD_FALL));
  endfunction

endpackage

// File: rtl/qdrc_cal_window.sv
// Purpose: tracks the current run of good taps and keeps the widest (earliest on ties).
// Latency: best_* valid the cycle after the upd strobe carrying last=1.
// Backpressure: none; consumes one evaluation per upd strobe.
module qdrc_cal_window
  import qdrc_cal_pkg::*;
#(
  parameter int TAP_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                upd,
  input  logic [TAP_BITS-1:0] tap,
  input  logic                good,
  input  logic [1:0]          value,
  input  logic                last,
  output logic [TAP_BITS-1:0] best_start,
  output logic [TAP_BITS:0]   best_len,
  output logic [1:0]          best_val
);

  // run length needs one extra bit so a full-sweep run (2^TAP_BITS) fits
  localparam logic [TAP_BITS:0] LEN_ONE = (TAP_BITS+1)'(1);

  logic [TAP_BITS-1:0] run_start_q, run_start_d, best_start_q, best_start_d;
  logic [TAP_BITS:0]   run_len_q, run_len_d, best_len_q, best_len_d;
  logic [1:0]          run_val_q, run_val_d, best_val_q, best_val_d;
  logic                extend;

  // close the run that ends on this tap, then open/extend; a run still open at the last tap also closes
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    run_val_d    = run_val_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    best_val_d   = best_val_q;
    extend       = good && (run_len_q != '0) && (value == run_val_q);
    if (clear) begin
      run_start_d  = '0;
      run_len_d    = '0;
      run_val_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
      best_val_d   = '0;
    end else if (upd) begin
      if (!extend && (run_len_q > best_len_q)) begin
        best_start_d = run_start_q;
        best_len_d   = run_len_q;
        best_val_d   = run_val_q;
      end
      if (extend) begin
        run_len_d = run_len_q + LEN_ONE;
      end else if (good) begin
        run_start_d = tap;
        run_len_d   = LEN_ONE;
        run_val_d   = value;
      end else begin
        run_len_d = '0;
      end
      if (last && (run_len_d > best_len_d)) begin
        best_start_d = run_start_d;
        best_len_d   = run_len_d;
        best_val_d   = run_val_d;
      end
    end
  end

  // run and best-window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      run_val_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      best_val_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      run_val_q    <= run_val_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      best_val_q   <= best_val_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;
  assign best_val   = best_val_q;

endmodule

// File: rtl/qdrc_hw_cal_seq.sv
// Purpose: per-bit QDR PHY eye sweep, centring and half-cycle alignment, with CPU pass-through.
// Latency: ~(SETTLE_CYCLES+3) cycles per tap per bit plus centring; override path is combinational.
// Backpressure: stalls on cal_rdy / data_sampled (bounded by TIMEOUT_CYCLES); cal_start ignored while busy.
module qdrc_hw_cal_seq
  import qdrc_cal_pkg::*;
#(
  parameter int DATA_WIDTH     = 36,
  parameter int TAP_BITS       = 6,
  parameter int MIN_WINDOW     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       cal_start,
  input  logic       sw_override,
  input  logic       sw_cal_en,
  input  logic       sw_dll_en,
  input  logic       sw_dll_inc_dec_n,
  input  logic       sw_dll_rst,
  input  logic       sw_align_en,
  input  logic       sw_align_strb,
  input  logic [7:0] sw_bit_select,
  output logic       cal_en,
  input  logic       cal_rdy,
  output logic [7:0] bit_select,
  output logic       dll_en,
  output logic       dll_inc_dec_n,
  output logic       dll_rst,
  output logic       align_en,
  output logic       align_strb,
  input  logic [1:0] data_value,
  input  logic       data_sampled,
  input  logic       data_valid,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [7:0] fail_bit,
  output logic [1:0] fail_code
);

  // one timer serves settle, timeouts and centre pacing; sized for the longest of them
  localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + (4 << TAP_BITS)) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TAP_BITS-1:0] TAP_MAX    = '1;
  localparam logic [TAP_BITS-1:0] TAP_ONE    = TAP_BITS'(1);
  localparam logic [TAP_BITS:0]   LEN_ONE    = (TAP_BITS+1)'(1);
  localparam logic [TAP_BITS:0]   MIN_LEN    = (TAP_BITS+1)'(MIN_WINDOW);
  localparam logic [7:0]          BIT_LAST   = 8'(DATA_WIDTH - 1);

  cal_state_e          state_q, state_d;
  logic [7:0]          bit_q, bit_d;
  logic [TAP_BITS-1:0] tap_q, tap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TAP_BITS:0]   pulses_q, pulses_d, centre_q, centre_d;
  logic                smp_good_q, smp_good_d;
  logic [1:0]          smp_val_q, smp_val_d;
  logic                cal_en_q, cal_en_d;
  logic [7:0]          bit_sel_q, bit_sel_d;
  logic                dll_en_q, dll_en_d, dll_inc_q, dll_inc_d, dll_rst_q, dll_rst_d;
  logic                align_en_q, align_en_d, align_strb_q, align_strb_d;
  logic                cal_done_q, cal_done_d, cal_fail_q, cal_fail_d;
  logic [7:0]          fail_bit_q, fail_bit_d;
  logic [1:0]          fail_code_q, fail_code_d;

  logic                win_clear, win_upd, win_last;
  logic [TAP_BITS-1:0] best_start;
  logic [TAP_BITS:0]   best_len;
  logic [1:0]          best_val;
  logic                ovr;

  qdrc_cal_window #(.TAP_BITS(TAP_BITS)) u_window (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n_i),
    .clear      (win_clear),
    .upd        (win_upd),
    .tap        (tap_q),
    .good       (smp_good_q),
    .value      (smp_val_q),
    .last       (win_last),
    .best_start (best_start),
    .best_len   (best_len),
    .best_val   (best_val)
  );

  // sequencer next-state and PHY control; dll_en/dll_rst/align_strb are single-cycle pulses
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    tap_d        = tap_q;
    pulses_d     = pulses_q;
    centre_d     = centre_q;
    smp_good_d   = smp_good_q;
    smp_val_d    = smp_val_q;
    cal_en_d     = cal_en_q;
    bit_sel_d    = bit_sel_q;
    dll_en_d     = 1'b0;
    dll_inc_d    = dll_inc_q;
    dll_rst_d    = 1'b0;
    align_en_d   = align_en_q;
    align_strb_d = 1'b0;
    cal_done_d   = cal_done_q;
    cal_fail_d   = cal_fail_q;
    fail_bit_d   = fail_bit_q;
    fail_code_d  = fail_code_q;
    win_clear    = 1'b0;
    win_upd      = 1'b0;
    win_last     = (tap_q == TAP_MAX);

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start && !sw_override) begin
          cal_done_d  = 1'b0;
          cal_fail_d  = 1'b0;
          fail_bit_d  = '0;
          fail_code_d = FAIL_NONE;
          cal_en_d    = 1'b1;
          bit_d       = '0;
          align_en_d  = 1'b0;
          state_d     = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (cal_rdy) begin
          state_d = ST_SEL_BIT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_FAIL;
          cal_fail_d  = 1'b1;
          cal_en_d    = 1'b0;
          fail_bit_d  = bit_q;
          fail_code_d = FAIL_RDY_TO;
        end
      end
      ST_SEL_BIT: begin
        bit_sel_d  = bit_q;
        dll_rst_d  = 1'b1;
        tap_d      = '0;
        win_clear  = 1'b1;
        align_en_d = 1'b0;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (data_sampled) begin
          smp_good_d = is_good(data_valid, data_value);
          smp_val_d  = data_value;
          state_d    = ST_EVAL;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_FAIL;
          cal_fail_d  = 1'b1;
          cal_en_d    = 1'b0;
          fail_bit_d  = bit_q;
          fail_code_d = FAIL_SAMPLE_TO;
        end
      end
      ST_EVAL: begin
        win_upd = 1'b1;
        state_d = win_last ? ST_CHECK : ST_STEP;
      end
      ST_STEP: begin
        dll_inc_d = 1'b1;
        dll_en_d  = 1'b1;
        tap_d     = tap_q + TAP_ONE;
        state_d   = ST_SETTLE;
      end
      ST_CHECK: begin
        if (best_len < MIN_LEN) begin
          state_d     = ST_FAIL;
          cal_fail_d  = 1'b1;
          cal_en_d    = 1'b0;
          fail_bit_d  = bit_q;
          fail_code_d = FAIL_NARROW;
        end else begin
          centre_d  = {1'b0, best_start} + (best_len >> 1);
          dll_rst_d = 1'b1;
          pulses_d  = '0;
          state_d   = ST_CENTRE;
        end
      end
      ST_CENTRE: begin
        // even timer cycles issue a pulse so each increment has a quiet cycle after it
        if (pulses_q == centre_q) begin
          state_d = ST_ALIGN;
        end else if (!cnt_q[0]) begin
          dll_en_d  = 1'b1;
          dll_inc_d = 1'b1;
          pulses_d  = pulses_q + LEN_ONE;
        end
      end
      ST_ALIGN: begin
        align_en_d   = (best_val == GOOD_FALL);
        align_strb_d = 1'b1;
        state_d      = ST_NEXT;
      end
      ST_NEXT: begin
        if (bit_q == BIT_LAST) begin
          state_d    = ST_DONE;
          cal_done_d = 1'b1;
          cal_en_d   = 1'b0;
        end else begin
          bit_d   = bit_q + 8'd1;
          state_d = ST_SEL_BIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = (state_d != state_q) ? '0 : (cnt_q + CNT_ONE);
  end

  // sequencer state, timers and registered PHY/status outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      bit_q        <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      pulses_q     <= '0;
      centre_q     <= '0;
      smp_good_q   <= 1'b0;
      smp_val_q    <= '0;
      cal_en_q     <= 1'b0;
      bit_sel_q    <= '0;
      dll_en_q     <= 1'b0;
      dll_inc_q    <= 1'b0;
      dll_rst_q    <= 1'b0;
      align_en_q   <= 1'b0;
      align_strb_q <= 1'b0;
      cal_done_q   <= 1'b0;
      cal_fail_q   <= 1'b0;
      fail_bit_q   <= '0;
      fail_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      pulses_q     <= pulses_d;
      centre_q     <= centre_d;
      smp_good_q   <= smp_good_d;
      smp_val_q    <= smp_val_d;
      cal_en_q     <= cal_en_d;
      bit_sel_q    <= bit_sel_d;
      dll_en_q     <= dll_en_d;
      dll_inc_q    <= dll_inc_d;
      dll_rst_q    <= dll_rst_d;
      align_en_q   <= align_en_d;
      align_strb_q <= align_strb_d;
      cal_done_q   <= cal_done_d;
      cal_fail_q   <= cal_fail_d;
      fail_bit_q   <= fail_bit_d;
      fail_code_q  <= fail_code_d;
    end
  end

  // the CPU owns the PHY only while the sequencer is idle; reset forces everything low
  assign cal_busy = !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign ovr      = sw_override && !cal_busy && wb_rst_n_i;

  assign cal_en        = ovr ? sw_cal_en        : cal_en_q;
  assign bit_select    = ovr ? sw_bit_select    : bit_sel_q;
  assign dll_en        = ovr ? sw_dll_en        : dll_en_q;
  assign dll_inc_dec_n = ovr ? sw_dll_inc_dec_n : dll_inc_q;
  assign dll_rst       = ovr ? sw_dll_rst       : dll_rst_q;
  assign align_en      = ovr ? sw_align_en      : align_en_q;
  assign align_strb    = ovr ? sw_align_strb    : align_strb_q;

  assign cal_done  = cal_done_q;
  assign cal_fail  = cal_fail_q;
  assign fail_bit  = fail_bit_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_qdrc_hw_cal_seq.sv
module tb_qdrc_hw_cal_seq;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cal_start = 1'b0, sw_override = 1'b0;
  logic       sw_cal_en = 1'b0, sw_dll_en = 1'b0, sw_dll_inc_dec_n = 1'b0, sw_dll_rst = 1'b0;
  logic       sw_align_en = 1'b0, sw_align_strb = 1'b0;
  logic [7:0] sw_bit_select = '0;
  logic       cal_rdy = 1'b1;
  logic       cal_en, dll_en, dll_inc_dec_n, dll_rst, align_en, align_strb;
  logic [7:0] bit_select, fail_bit;
  logic [1:0] data_value, fail_code;
  logic       data_sampled, data_valid, cal_busy, cal_done, cal_fail;

  always #5 clk = ~clk;

  qdrc_hw_cal_seq #(.DATA_WIDTH(NB), .TAP_BITS(6), .MIN_WINDOW(4),
                    .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(1024)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .cal_start(cal_start), .sw_override(sw_override),
    .sw_cal_en(sw_cal_en), .sw_dll_en(sw_dll_en), .sw_dll_inc_dec_n(sw_dll_inc_dec_n),
    .sw_dll_rst(sw_dll_rst), .sw_align_en(sw_align_en), .sw_align_strb(sw_align_strb),
    .sw_bit_select(sw_bit_select), .cal_en(cal_en), .cal_rdy(cal_rdy), .bit_select(bit_select),
    .dll_en(dll_en), .dll_inc_dec_n(dll_inc_dec_n), .dll_rst(dll_rst), .align_en(align_en),
    .align_strb(align_strb), .data_value(data_value), .data_sampled(data_sampled),
    .data_valid(data_valid), .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail),
    .fail_bit(fail_bit), .fail_code(fail_code)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int b; int tap; logic aen; } ev_t;
  ev_t exp_q[$];
  ev_t got_q[$];

  logic [26:0] outs;
  logic [13:0] stat;
  assign outs = {cal_en, bit_select, dll_en, dll_inc_dec_n, dll_rst, align_en, align_strb,
                 cal_busy, cal_done, cal_fail, fail_bit, fail_code};
  assign stat = {cal_busy, cal_done, cal_fail, cal_en, fail_code, fail_bit};

  // ---------------- PHY model ----------------
  int         lo0[NB], hi0[NB], lo1[NB], hi1[NB];
  logic [1:0] v0[NB], v1[NB];
  int         phy_tap, scnt;
  logic [7:0] prev_sel;
  logic       stuck = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phy_tap <= 0; scnt <= 0; prev_sel <= '0;
    end else begin
      if (dll_rst) phy_tap <= 0;
      else if (dll_en) phy_tap <= dll_inc_dec_n ? phy_tap + 1 : phy_tap - 1;
      if (dll_rst || dll_en || (bit_select != prev_sel)) scnt <= 0;
      else if (scnt < 3) scnt <= scnt + 1;
      prev_sel <= bit_select;
    end
  end

  assign data_sampled = !stuck && (scnt >= 3);

  // outside the eye: odd taps are "valid" but garbage 2'b11, even taps carry 2'b10 but are not valid
  always @* begin
    data_valid = phy_tap[0];
    data_value = phy_tap[0] ? 2'b11 : 2'b10;
    if (bit_select < 8'd4) begin
      if (phy_tap >= lo0[bit_select[1:0]] && phy_tap <= hi0[bit_select[1:0]]) begin
        data_valid = 1'b1; data_value = v0[bit_select[1:0]];
      end else if (phy_tap >= lo1[bit_select[1:0]] && phy_tap <= hi1[bit_select[1:0]]) begin
        data_valid = 1'b1; data_value = v1[bit_select[1:0]];
      end
    end
  end

  // capture the centred tap and alignment whenever the sequencer strobes alignment
  always @(negedge clk) begin
    if (rst_n && align_strb && !sw_override) got_q.push_back('{int'(bit_select), phy_tap, align_en});
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic set_bit(input int b, input int l0, input int h0, input logic [1:0] w0,
                         input int l1, input int h1, input logic [1:0] w1);
    lo0[b] = l0; hi0[b] = h0; v0[b] = w0; lo1[b] = l1; hi1[b] = h1; v1[b] = w1;
  endtask

  task automatic set_all(input int l, input int h, input logic [1:0] w);
    for (int b = 0; b < NB; b++) set_bit(b, l, h, w, 1, 0, 2'b10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cal_start = 1'b0; sw_override = 1'b0; cal_rdy = 1'b1; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic start_cal();
    exp_q.delete(); got_q.delete();
    @(posedge clk); #1 cal_start = 1'b1;
    @(posedge clk); #1 cal_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cal_busy) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    repeat (5) @(posedge clk); #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_idle_hold: got %h want 0", outs); end
  endtask

  task automatic test_override();
    sw_override = 1'b1; sw_bit_select = 8'd7; sw_cal_en = 1'b1; sw_dll_en = 1'b1;
    sw_dll_inc_dec_n = 1'b1; sw_dll_rst = 1'b0; sw_align_en = 1'b1; sw_align_strb = 1'b0;
    #1;
    checks++;
    if ({cal_en, bit_select, dll_en, dll_inc_dec_n, dll_rst, align_en, align_strb} !== {1'b1, 8'd7, 5'b11010}) begin
      errors++; $display("FAIL override_mirror: got %b/%0d/%b want 1/7/11010", cal_en, bit_select,
                         {dll_en, dll_inc_dec_n, dll_rst, align_en, align_strb});
    end
    sw_dll_en = 1'b0; sw_dll_rst = 1'b1; #1;
    checks++;
    if ({dll_en, dll_rst} !== 2'b01) begin errors++; $display("FAIL override_pulse: got %b want 01", {dll_en, dll_rst}); end
    sw_dll_rst = 1'b0;
    cal_start = 1'b1; @(posedge clk); #1 cal_start = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({cal_busy, cal_en} !== 2'b01) begin errors++; $display("FAIL override_start_ignored: got busy,en=%b want 01", {cal_busy, cal_en}); end
    sw_override = 1'b0; #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL override_release: got %h want 0", outs); end
    {sw_cal_en, sw_dll_inc_dec_n, sw_align_en} = '0; sw_bit_select = '0;
  endtask

  task automatic test_basic_pass();
    ev_t e, g; bit ok;
    set_all(10, 29, 2'b10);
    start_cal();
    for (int b = 0; b < NB; b++) exp_q.push_back('{b, 20, 1'b0});
    checks++;
    if ({cal_busy, cal_en, cal_done, cal_fail} !== 4'b1100) begin errors++; $display("FAIL basic_start: got %b want 1100", {cal_busy, cal_en, cal_done, cal_fail}); end
    wait_idle(10000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: busy=%b want 0", cal_busy); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g.b != e.b || g.tap != e.tap || g.aen !== e.aen) begin
        errors++; $display("FAIL basic_centre: got bit%0d tap%0d aen%b want bit%0d tap%0d aen%b", g.b, g.tap, g.aen, e.b, e.tap, e.aen);
      end
    end
    checks++;
    if (stat !== {4'b0100, 2'd0, 8'd0}) begin errors++; $display("FAIL basic_status: got %b want %b", stat, {4'b0100, 2'd0, 8'd0}); end
  endtask

  task automatic test_align_fall();
    ev_t e, g; bit ok;
    set_all(10, 29, 2'b10);
    set_bit(2, 40, 47, 2'b01, 1, 0, 2'b10);
    start_cal();
    for (int b = 0; b < NB; b++) exp_q.push_back((b == 2) ? '{b, 44, 1'b1} : '{b, 20, 1'b0});
    checks++;
    if ({cal_busy, cal_done, cal_fail} !== 3'b100) begin errors++; $display("FAIL fall_done_cleared: got %b want 100", {cal_busy, cal_done, cal_fail}); end
    wait_idle(10000, ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL fall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g.b != e.b || g.tap != e.tap || g.aen !== e.aen) begin
        errors++; $display("FAIL fall_centre: got bit%0d tap%0d aen%b want bit%0d tap%0d aen%b", g.b, g.tap, g.aen, e.b, e.tap, e.aen);
      end
    end
    checks++;
    if (stat !== {4'b0100, 2'd0, 8'd0}) begin errors++; $display("FAIL fall_status: got %b want %b", stat, {4'b0100, 2'd0, 8'd0}); end
  endtask

  task automatic test_ties_full();
    ev_t e, g; bit ok;
    set_bit(0, 0, 63, 2'b10, 1, 0, 2'b10);      // whole sweep good -> len 64, centre 32
    set_bit(1, 5, 10, 2'b10, 30, 35, 2'b10);    // equal runs -> earliest, centre 8
    set_bit(2, 12, 15, 2'b10, 16, 25, 2'b01);   // value change splits run -> 16..25, centre 21
    set_bit(3, 10, 29, 2'b10, 1, 0, 2'b10);
    start_cal();
    exp_q.push_back('{0, 32, 1'b0});
    exp_q.push_back('{1, 8, 1'b0});
    exp_q.push_back('{2, 21, 1'b1});
    exp_q.push_back('{3, 20, 1'b0});
    wait_idle(10000, ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL ties_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g.b != e.b || g.tap != e.tap || g.aen !== e.aen) begin
        errors++; $display("FAIL ties_centre: got bit%0d tap%0d aen%b want bit%0d tap%0d aen%b", g.b, g.tap, g.aen, e.b, e.tap, e.aen);
      end
    end
    checks++;
    if (cal_done !== 1'b1) begin errors++; $display("FAIL ties_done: got %b want 1", cal_done); end
  endtask

  task automatic test_narrow_fail();
    ev_t e, g; bit ok;
    set_all(10, 29, 2'b10);
    set_bit(3, 20, 22, 2'b10, 1, 0, 2'b10);
    start_cal();
    for (int b = 0; b < 3; b++) exp_q.push_back('{b, 20, 1'b0});
    wait_idle(10000, ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL narrow_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g.b != e.b || g.tap != e.tap || g.aen !== e.aen) begin
        errors++; $display("FAIL narrow_centre: got bit%0d tap%0d want bit%0d tap%0d", g.b, g.tap, e.b, e.tap);
      end
    end
    checks++;
    if (stat !== {4'b0010, 2'd1, 8'd3}) begin errors++; $display("FAIL narrow_status: got %b want %b", stat, {4'b0010, 2'd1, 8'd3}); end
  endtask

  task automatic test_zero_eye();
    bit ok;
    set_all(10, 29, 2'b10);
    set_bit(0, 1, 0, 2'b10, 1, 0, 2'b10);
    start_cal();
    wait_idle(3000, ok);
    checks++;
    if (!ok || got_q.size() != 0) begin errors++; $display("FAIL zero_events: got %0d want 0", got_q.size()); end
    checks++;
    if (stat !== {4'b0010, 2'd1, 8'd0}) begin errors++; $display("FAIL zero_status: got %b want %b", stat, {4'b0010, 2'd1, 8'd0}); end
  endtask

  task automatic test_rdy_timeout();
    bit ok;
    cal_rdy = 1'b0;
    start_cal();
    repeat (1000) @(posedge clk); #1;
    checks++;
    if ({cal_busy, cal_fail} !== 2'b10) begin errors++; $display("FAIL rdy_early: got busy,fail=%b want 10", {cal_busy, cal_fail}); end
    wait_idle(100, ok);
    checks++;
    if (!ok || stat !== {4'b0010, 2'd2, 8'd0}) begin errors++; $display("FAIL rdy_timeout: got %b want %b", stat, {4'b0010, 2'd2, 8'd0}); end
    cal_rdy = 1'b1;
  endtask

  task automatic test_sample_timeout();
    bit ok;
    stuck = 1'b1;
    start_cal();
    checks++;
    if ({cal_busy, cal_fail, fail_code} !== 4'b1000) begin errors++; $display("FAIL sample_fail_cleared: got %b want 1000", {cal_busy, cal_fail, fail_code}); end
    wait_idle(3000, ok);
    checks++;
    if (!ok || stat !== {4'b0010, 2'd3, 8'd0}) begin errors++; $display("FAIL sample_timeout: got %b want %b", stat, {4'b0010, 2'd3, 8'd0}); end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_all(10, 29, 2'b10);
    start_cal();
    repeat (300) @(posedge clk); #2;
    checks++;
    if ({cal_busy, cal_en} !== 2'b11) begin errors++; $display("FAIL midrst_busy: got %b want 11", {cal_busy, cal_en}); end
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", outs); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midrst_after: got %h want 0", outs); end
  endtask

  initial begin
    test_reset();
    test_override();
    test_basic_pass();
    test_align_fall();
    test_ties_full();
    test_narrow_fail();
    test_zero_eye();
    test_rdy_timeout();
    test_sample_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
